// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU register-file constants for the regfile/scoreboard slice.
package regfile_scoreboard_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned NREG_DEFAULT = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    function automatic logic is_zero_reg(input logic [REG_AW-1:0] r);
        return r == REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_reg_scoreboard.sv
// Per-register pending-write counters with hazard lookup and sticky retire error.
module reg_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEFAULT,
    parameter int unsigned CNTW = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inc,
    input  logic [REG_AW-1:0] inc_addr,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              dest_full,
    output logic              sb_err
);

    logic [CNTW-1:0] cnt [NREG];
    logic            dec;
    logic            err;

    // A single pending write retiring this cycle is covered by the bypass path.
    function automatic logic hazard(input logic [REG_AW-1:0] r);
        return !is_zero_reg(r) && (cnt[r] != '0)
            && !((cnt[r] == CNTW'(1)) && wb_wen && (wb_addr == r));
    endfunction

    always_comb begin
        hazard1   = hazard(raddr1);
        hazard2   = hazard(raddr2);
        dest_full = !is_zero_reg(inc_addr) && (cnt[inc_addr] == '1);
        dec       = wb_wen && !is_zero_reg(wb_addr) && (cnt[wb_addr] != '0);
        err       = wb_wen && !is_zero_reg(wb_addr) && (cnt[wb_addr] == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NREG; i++) cnt[i] <= '0;
            sb_err <= 1'b0;
        end else begin
            if (err) sb_err <= 1'b1;
            for (int unsigned r = 1; r < NREG; r++) begin
                if (inc && (inc_addr == REG_AW'(r)) && !(dec && (wb_addr == REG_AW'(r))))
                    cnt[r] <= cnt[r] + CNTW'(1);
                else if (dec && (wb_addr == REG_AW'(r)) && !(inc && (inc_addr == REG_AW'(r))))
                    cnt[r] <= cnt[r] - CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-through bypass and RAW-hazard decode stall.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEFAULT,
    parameter int unsigned DW   = DW_DEFAULT,
    parameter int unsigned CNTW = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_regsrc,
    input  logic [DW-1:0]     wb_regwdata,
    input  logic              de_ren1,
    input  logic              de_ren2,
    input  logic [REG_AW-1:0] de_raddr1,
    input  logic [REG_AW-1:0] de_raddr2,
    output logic [DW-1:0]     de_rdata1,
    output logic [DW-1:0]     de_rdata2,
    input  logic              de_issue,
    input  logic [REG_AW-1:0] de_dest,
    output logic              de_stall,
    output logic              sb_err
);

    logic [DW-1:0] rf [NREG];
    logic          hazard1;
    logic          hazard2;
    logic          dest_full;
    logic          inc;

    function automatic logic [DW-1:0] read_port(input logic [REG_AW-1:0] a);
        if (is_zero_reg(a))                   return '0;
        else if (wb_wen && (wb_regsrc == a))  return wb_regwdata;
        else                                  return rf[a];
    endfunction

    always_comb begin
        de_rdata1 = read_port(de_raddr1);
        de_rdata2 = read_port(de_raddr2);
        de_stall  = (de_ren1 && hazard1) || (de_ren2 && hazard2) || (de_issue && dest_full);
        inc       = de_issue && !de_stall && !is_zero_reg(de_dest);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_wen && !is_zero_reg(wb_regsrc)) begin
            rf[wb_regsrc] <= wb_regwdata;
        end
    end

    reg_scoreboard #(
        .NREG(NREG),
        .CNTW(CNTW)
    ) u_sb (
        .clk       (clk),
        .resetn    (resetn),
        .inc       (inc),
        .inc_addr  (de_dest),
        .wb_wen    (wb_wen),
        .wb_addr   (wb_regsrc),
        .raddr1    (de_raddr1),
        .raddr2    (de_raddr2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .dest_full (dest_full),
        .sb_err    (sb_err)
    );

endmodule
